// File: rtl/restador_serial.sv
// Bit-serial N-bit unsigned subtractor: one full-subtractor slice, LSB first,
// with a registered borrow, a start handshake and a one-cycle completion pulse.
module restador_serial #(
  parameter int N = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         INICIO,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] R,
  output logic         AN,
  output logic         OCUPADO,
  output logic         LISTO
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESTA = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   sa;
  logic [N-1:0]   sb;
  logic [N-1:0]   sr;
  logic           bw;
  logic [CW-1:0]  cnt;
  logic           bit_a;
  logic           bit_b;
  logic           d;
  logic           bw_next;
  logic           last_bit;
  logic           accept;
  logic [N-1:0]   sr_shift;

  // Full-subtractor slice; the new difference bit enters the result from the MSB side.
  always_comb begin
    bit_a    = sa[0];
    bit_b    = sb[0];
    d        = bit_a ^ bit_b ^ bw;
    bw_next  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bw);
    sr_shift = (sr >> 1) | (N'(d) << (N - 1));
    last_bit = (cnt == CW'(N - 1));
  end

  // Next-state logic; FIN accepts a new start exactly like IDLE.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (INICIO) begin
          accept     = 1'b1;
          state_next = RESTA;
        end else begin
          state_next = IDLE;
        end
      end
      RESTA: begin
        if (last_bit) begin
          state_next = FIN;
        end else begin
          state_next = RESTA;
        end
      end
      FIN: begin
        if (INICIO) begin
          accept     = 1'b1;
          state_next = RESTA;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and registered status flags.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= IDLE;
      OCUPADO <= 1'b0;
      LISTO   <= 1'b0;
    end else begin
      state   <= state_next;
      OCUPADO <= (state_next == RESTA);
      LISTO   <= (state_next == FIN);
    end
  end

  // Operand/result shift registers; R and AN only change on the terminal bit.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sa  <= '0;
      sb  <= '0;
      sr  <= '0;
      bw  <= 1'b0;
      cnt <= '0;
      R   <= '0;
      AN  <= 1'b0;
    end else if (accept) begin
      sa  <= A;
      sb  <= B;
      sr  <= '0;
      bw  <= 1'b0;
      cnt <= '0;
    end else if (state == RESTA) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= sr_shift;
      bw  <= bw_next;
      cnt <= cnt + CW'(1);
      if (last_bit) begin
        R  <= sr_shift;
        AN <= bw_next;
      end
    end
  end

endmodule

// File: tb/tb_restador_serial.sv
// Self-checking bench for restador_serial: directed cases, back-to-back chaining,
// mid-operation reset, an N=1 instance and randomized operations against an arithmetic model.
module tb_restador_serial;

  localparam int N8 = 8;

  logic            CLK;
  logic            RST_N;
  logic            INICIO;
  logic [N8-1:0]   A;
  logic [N8-1:0]   B;
  logic [N8-1:0]   R;
  logic            AN;
  logic            OCUPADO;
  logic            LISTO;

  logic            INICIO1;
  logic [0:0]      A1;
  logic [0:0]      B1;
  logic [0:0]      R1;
  logic            AN1;
  logic            OCUPADO1;
  logic            LISTO1;

  int              n_checks;
  int              n_errors;
  logic [N8-1:0]   last_r;
  logic            last_an;

  restador_serial #(.N(N8)) dut (
    .CLK(CLK), .RST_N(RST_N), .INICIO(INICIO), .A(A), .B(B),
    .R(R), .AN(AN), .OCUPADO(OCUPADO), .LISTO(LISTO)
  );

  restador_serial #(.N(1)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .INICIO(INICIO1), .A(A1), .B(B1),
    .R(R1), .AN(AN1), .OCUPADO(OCUPADO1), .LISTO(LISTO1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation on the N=8 instance; expected values come from plain arithmetic.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    int          lat;
    int          busy;
    logic [7:0]  er;
    logic        ean;
    er  = a - b;
    ean = (a < b);
    @(negedge CLK);
    A = a; B = b; INICIO = 1'b1;
    @(posedge CLK);
    lat  = 0;
    busy = 0;
    for (int k = 1; k <= N8 + 4; k++) begin
      @(negedge CLK);
      INICIO = 1'b0;
      A = 8'($urandom);
      B = 8'($urandom);
      if (LISTO) begin
        lat = k;
        break;
      end
      busy += int'(OCUPADO);
      check_eq("r_hold", 32'(R), 32'(last_r));
      check_eq("an_hold", 32'(AN), 32'(last_an));
    end
    check_eq("latency", lat, N8 + 1);
    check_eq("busy_cycles", busy, N8);
    check_eq("r", 32'(R), 32'(er));
    check_eq("an", 32'(AN), 32'(ean));
    check_eq("busy_at_done", 32'(OCUPADO), 32'd0);
    last_r  = er;
    last_an = ean;
    @(negedge CLK);
    check_eq("listo_pulse", 32'(LISTO), 32'd0);
    check_eq("r_after", 32'(R), 32'(last_r));
  endtask

  task automatic run_op1(input logic x, input logic y);
    @(negedge CLK);
    A1 = x; B1 = y; INICIO1 = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    INICIO1 = 1'b0;
    check_eq("n1_busy", 32'(OCUPADO1), 32'd1);
    check_eq("n1_listo_early", 32'(LISTO1), 32'd0);
    @(negedge CLK);
    check_eq("n1_listo", 32'(LISTO1), 32'd1);
    check_eq("n1_r", 32'(R1), 32'(x ^ y));
    check_eq("n1_an", 32'(AN1), 32'(~x & y));
    @(negedge CLK);
    check_eq("n1_listo_pulse", 32'(LISTO1), 32'd0);
  endtask

  initial begin
    logic [7:0] ea;
    logic [7:0] eb;
    logic [7:0] er;
    int         ph;
    n_checks = 0;
    n_errors = 0;
    RST_N = 1'b0; INICIO = 1'b0; A = '0; B = '0;
    INICIO1 = 1'b0; A1 = '0; B1 = '0;
    ea = '0; eb = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_eq("rst_r", 32'(R), 32'd0);
    check_eq("rst_an", 32'(AN), 32'd0);
    check_eq("rst_busy", 32'(OCUPADO), 32'd0);
    check_eq("rst_listo", 32'(LISTO), 32'd0);
    check_eq("rst_n1_r", 32'(R1), 32'd0);
    check_eq("rst_n1_listo", 32'(LISTO1), 32'd0);
    RST_N   = 1'b1;
    last_r  = '0;
    last_an = 1'b0;

    run_op(8'd200, 8'd55);
    check_eq("dir_200_55", 32'(R), 32'd145);
    run_op(8'd5, 8'd9);
    run_op(8'd0, 8'hFF);
    run_op(8'hAA, 8'hAA);
    run_op(8'hFF, 8'h00);

    // INICIO held high with operands changing every cycle: period N+1.
    @(negedge CLK);
    A = 8'($urandom); B = 8'($urandom); INICIO = 1'b1;
    for (int i = 0; i < 4 * (N8 + 1); i++) begin
      @(posedge CLK);
      ph = i % (N8 + 1);
      if (ph == 0) begin
        ea = A;
        eb = B;
      end
      @(negedge CLK);
      check_eq("chain_listo", 32'(LISTO), 32'(ph == N8));
      check_eq("chain_busy", 32'(OCUPADO), 32'(ph != N8));
      if (ph == N8) begin
        er = ea - eb;
        check_eq("chain_r", 32'(R), 32'(er));
        check_eq("chain_an", 32'(AN), 32'(ea < eb));
        last_r  = er;
        last_an = (ea < eb);
      end else begin
        check_eq("chain_r_hold", 32'(R), 32'(last_r));
      end
      A = 8'($urandom);
      B = 8'($urandom);
      if (i == 4 * (N8 + 1) - 1) begin
        INICIO = 1'b0;
      end
    end

    // Reset in the middle of an operation aborts it and clears the result.
    run_op(8'd5, 8'd9);
    @(negedge CLK);
    A = 8'd100; B = 8'd30; INICIO = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    INICIO = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check_eq("abort_r", 32'(R), 32'd0);
    check_eq("abort_an", 32'(AN), 32'd0);
    check_eq("abort_busy", 32'(OCUPADO), 32'd0);
    check_eq("abort_listo", 32'(LISTO), 32'd0);
    RST_N   = 1'b1;
    last_r  = '0;
    last_an = 1'b0;
    for (int k = 0; k < N8 + 3; k++) begin
      @(negedge CLK);
      check_eq("abort_no_listo", 32'(LISTO), 32'd0);
      check_eq("abort_idle", 32'(OCUPADO), 32'd0);
    end
    run_op(8'd30, 8'd100);
    check_eq("after_abort_r", 32'(R), 32'hBA);

    run_op1(1'b0, 1'b0);
    run_op1(1'b0, 1'b1);
    run_op1(1'b1, 1'b0);
    run_op1(1'b1, 1'b1);

    for (int n = 0; n < 1000; n++) begin
      run_op(8'($urandom), 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
